stream_demux_1ton: RTL

STREAM_DEMUX_1TON -- requirements
Module: stream_demux_1ton

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/stream_reg_slice.sv | 40 ++++
 rtl/stream_demux_1ton.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_demux_pkg : shared FSM states and default widths          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package stream_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_OUT  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_reg_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_reg_slice : single valid/ready output register stage      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module stream_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Reload whenever empty or draining this cycle, so a steady stream has no bubbles.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux_1ton.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_demux_1ton : packet demux, 1 input stream to N_OUT streams |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_last,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              drop_pulse,
  output logic [7:0]        drop_cnt
);

  localparam int              c_SLICE_W = DATA_W + 1 + SEL_W;
  localparam logic [SEL_W:0]  c_N_OUT   = (SEL_W + 1)'(N_OUT);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ch_q;
  logic               r_drop_pulse;
  logic [7:0]         r_drop_cnt;

  logic               w_in_range;
  logic               w_in_xfer;
  logic               w_route;
  logic               w_drop_done;
  logic               w_slice_ready;
  logic               w_out_v;
  logic               w_out_ready;
  logic [SEL_W-1:0]   w_load_ch;
  logic [SEL_W-1:0]   w_out_ch;
  logic [c_SLICE_W-1:0] w_slice_in;
  logic [c_SLICE_W-1:0] w_slice_out;

  assign w_in_range = ({1'b0, s_sel} < c_N_OUT);
  assign s_ready    = rst_n && ((r_state == DROP) || w_slice_ready);
  assign w_in_xfer  = s_valid && s_ready;

  // Only the first beat (IDLE) consults s_sel; later beats follow the latched channel.
  assign w_route    = (r_state == FWD) || ((r_state == IDLE) && w_in_range);
  assign w_load_ch  = (r_state == FWD) ? r_ch_q : s_sel;
  assign w_slice_in = {s_last, w_load_ch, s_data};

  assign w_drop_done = w_in_xfer && s_last &&
                       ((r_state == DROP) || ((r_state == IDLE) && !w_in_range));

  stream_reg_slice #(
    .WIDTH (c_SLICE_W)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (s_valid && rst_n && w_route),
    .o_ready (w_slice_ready),
    .i_data  (w_slice_in),
    .o_valid (w_out_v),
    .i_ready (w_out_ready),
    .o_data  (w_slice_out)
  );

  assign {m_last, w_out_ch, m_data} = w_slice_out;

  for (genvar k = 0; k < N_OUT; k++) begin : g_mvalid
    assign m_valid[k] = w_out_v && (w_out_ch == SEL_W'(k));
  end

  // Only the ready of the channel currently holding the beat matters.
  assign w_out_ready = |(m_valid & m_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ch_q       <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_drop_pulse <= w_drop_done;
      if (w_drop_done && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            if (w_in_range) begin
              r_ch_q <= s_sel;
              if (!s_last) begin
                r_state <= FWD;
              end
            end else if (!s_last) begin
              r_state <= DROP;
            end
          end
        end
        FWD, DROP: begin
          if (w_in_xfer && s_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
